// File: rtl/video_timing_gen.sv
// video_timing_gen: programmable raster timing generator with a run-time
// selectable test pattern, active-area coordinates and a frame counter.
//
// Ports:
//   clock        pixel clock
//   reset_n      asynchronous active-low reset
//   enable       count enable; low freezes counters, shadows and outputs
//   pattern_sel  0 colorbar, 1 gray ramp, 2 grid, 3 solid
//   solid_color  {R,G,B} colour for the solid pattern
//   hsync/vsync  syncs, active level set by HSYNC_POL / VSYNC_POL
//   de           active-video enable
//   pixel_r/g/b  pattern pixel, zero during blanking
//   hcount/vcount active x/y coordinate, zero during blanking
//   frame_start  one-cycle pulse on the output cycle decoding position (0,0)
//   frame_count  completed-frame counter (wraps 255 -> 0)
//
// Every output is registered one clock after the counter state it decodes.
// Optional feature: define VIDEO_TIMING_GEN_SCROLL_EN to scroll patterns
// 0 and 1 horizontally by one pixel per frame.

module video_timing_gen #(
  parameter int unsigned H_TOTAL    = 800,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BACKP    = 48,
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned V_TOTAL    = 525,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BACKP    = 33,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned HSYNC_POL  = 0,
  parameter int unsigned VSYNC_POL  = 0,
  parameter int unsigned COLOR_BITS = 8
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      enable,
  input  logic [1:0]                pattern_sel,
  input  logic [3*COLOR_BITS-1:0]   solid_color,
  output logic                      hsync,
  output logic                      vsync,
  output logic                      de,
  output logic [COLOR_BITS-1:0]     pixel_r,
  output logic [COLOR_BITS-1:0]     pixel_g,
  output logic [COLOR_BITS-1:0]     pixel_b,
  output logic [11:0]               hcount,
  output logic [11:0]               vcount,
  output logic                      frame_start,
  output logic [7:0]                frame_count
);

  localparam int unsigned CW = 12;
  localparam int unsigned CB = COLOR_BITS;
  localparam int unsigned PW = 3 * COLOR_BITS;
  localparam int unsigned FW = 8;

  localparam logic [CW-1:0] H_LAST      = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST      = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_SYNC_END  = CW'(H_SYNC);
  localparam logic [CW-1:0] V_SYNC_END  = CW'(V_SYNC);
  localparam logic [CW-1:0] H_ACT_START = CW'(H_SYNC + H_BACKP);
  localparam logic [CW-1:0] H_ACT_END   = CW'(H_SYNC + H_BACKP + H_ACTIVE);
  localparam logic [CW-1:0] V_ACT_START = CW'(V_SYNC + V_BACKP);
  localparam logic [CW-1:0] V_ACT_END   = CW'(V_SYNC + V_BACKP + V_ACTIVE);

  // Bar width; a zero width (H_ACTIVE < 8) makes BARS_END zero so every
  // active pixel falls into the black remainder and the divisor is unused.
  localparam int unsigned   BAR_W    = H_ACTIVE / 8;
  localparam logic [CW-1:0] BAR_DIV  = CW'((BAR_W == 0) ? 1 : BAR_W);
  localparam logic [CW-1:0] BARS_END = CW'(BAR_W * 8);

  localparam logic HS_ON = 1'(HSYNC_POL);
  localparam logic VS_ON = 1'(VSYNC_POL);

  typedef enum logic [1:0] {
    PAT_BAR   = 2'd0,
    PAT_RAMP  = 2'd1,
    PAT_GRID  = 2'd2,
    PAT_SOLID = 2'd3
  } pattern_e;

  // Timing state and frame-boundary shadows
  logic [CW-1:0] hcnt_q, hcnt_d;
  logic [CW-1:0] vcnt_q, vcnt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  pattern_e      pat_q, pat_d;
  logic [PW-1:0] solid_q, solid_d;

  // Registered outputs
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          de_q, de_d;
  logic [PW-1:0] pix_q, pix_d;
  logic [CW-1:0] hcount_q, hcount_d;
  logic [CW-1:0] vcount_q, vcount_d;
  logic          fstart_q, fstart_d;
  logic [FW-1:0] fcount_q, fcount_d;

  // Decode of the current counter position
  logic          at_origin_c;
  logic          h_act_c, v_act_c, de_c;
  logic [CW-1:0] x_c, y_c, xs_c;
  logic [2:0]    bar_idx_c;
  logic [2:0]    bar_rgb_c;
  logic [PW-1:0] rgb_c;

  assign at_origin_c = (hcnt_q == '0) && (vcnt_q == '0);
  assign h_act_c     = (hcnt_q >= H_ACT_START) && (hcnt_q < H_ACT_END);
  assign v_act_c     = (vcnt_q >= V_ACT_START) && (vcnt_q < V_ACT_END);
  assign de_c        = h_act_c && v_act_c;
  assign x_c         = hcnt_q - H_ACT_START;
  assign y_c         = vcnt_q - V_ACT_START;

  // Horizontal source coordinate for the colorbar and ramp patterns
`ifdef VIDEO_TIMING_GEN_SCROLL_EN
  localparam int unsigned SW = CW + 1;
  logic [SW-1:0] xsum_c;
  assign xsum_c = SW'(x_c) + SW'(fcnt_q);
  // Single conditional subtract: wraps one screen width only
  assign xs_c   = (xsum_c >= SW'(H_ACTIVE)) ? CW'(xsum_c - SW'(H_ACTIVE))
                                            : CW'(xsum_c);
`else
  assign xs_c = x_c;
`endif

  // Colorbar: white, yellow, cyan, green, magenta, red, blue, black as {R,G,B}
  always_comb begin
    bar_idx_c = 3'(xs_c / BAR_DIV);
    bar_rgb_c = 3'b000;
    case (bar_idx_c)
      3'd0:    bar_rgb_c = 3'b111;
      3'd1:    bar_rgb_c = 3'b110;
      3'd2:    bar_rgb_c = 3'b011;
      3'd3:    bar_rgb_c = 3'b010;
      3'd4:    bar_rgb_c = 3'b101;
      3'd5:    bar_rgb_c = 3'b100;
      3'd6:    bar_rgb_c = 3'b001;
      default: bar_rgb_c = 3'b000;
    endcase
    if (xs_c >= BARS_END) begin
      bar_rgb_c = 3'b000;
    end
  end

  // Pattern pixel from the shadowed selection
  always_comb begin
    rgb_c = '0;
    case (pat_q)
      PAT_BAR:   rgb_c = {{CB{bar_rgb_c[2]}}, {CB{bar_rgb_c[1]}}, {CB{bar_rgb_c[0]}}};
      PAT_RAMP:  rgb_c = {3{CB'(xs_c)}};
      PAT_GRID:  rgb_c = ((x_c[4:0] == 5'd0) || (y_c[4:0] == 5'd0)) ? {PW{1'b1}} : '0;
      PAT_SOLID: rgb_c = solid_q;
      default:   rgb_c = '0;
    endcase
  end

  // Counter and shadow next state
  always_comb begin
    hcnt_d  = hcnt_q;
    vcnt_d  = vcnt_q;
    fcnt_d  = fcnt_q;
    pat_d   = pat_q;
    solid_d = solid_q;
    if (enable) begin
      if (hcnt_q == H_LAST) begin
        hcnt_d = '0;
        if (vcnt_q == V_LAST) begin
          vcnt_d = '0;
          fcnt_d = fcnt_q + FW'(1);
        end else begin
          vcnt_d = vcnt_q + CW'(1);
        end
      end else begin
        hcnt_d = hcnt_q + CW'(1);
      end
      // Pattern changes only land on frame boundaries
      if (at_origin_c) begin
        pat_d   = pattern_e'(pattern_sel);
        solid_d = solid_color;
      end
    end
  end

  // Output next state; everything holds while disabled except frame_start
  always_comb begin
    hsync_d  = hsync_q;
    vsync_d  = vsync_q;
    de_d     = de_q;
    pix_d    = pix_q;
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    fcount_d = fcount_q;
    fstart_d = 1'b0;
    if (enable) begin
      hsync_d  = (hcnt_q < H_SYNC_END) ? HS_ON : ~HS_ON;
      vsync_d  = (vcnt_q < V_SYNC_END) ? VS_ON : ~VS_ON;
      de_d     = de_c;
      pix_d    = de_c ? rgb_c : '0;
      hcount_d = de_c ? x_c : '0;
      vcount_d = de_c ? y_c : '0;
      fstart_d = at_origin_c;
      fcount_d = fcnt_q;
    end
  end

  // State registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hcnt_q   <= '0;
      vcnt_q   <= '0;
      fcnt_q   <= '0;
      pat_q    <= PAT_BAR;
      solid_q  <= '0;
      hsync_q  <= ~HS_ON;
      vsync_q  <= ~VS_ON;
      de_q     <= 1'b0;
      pix_q    <= '0;
      hcount_q <= '0;
      vcount_q <= '0;
      fstart_q <= 1'b0;
      fcount_q <= '0;
    end else begin
      hcnt_q   <= hcnt_d;
      vcnt_q   <= vcnt_d;
      fcnt_q   <= fcnt_d;
      pat_q    <= pat_d;
      solid_q  <= solid_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      de_q     <= de_d;
      pix_q    <= pix_d;
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
      fstart_q <= fstart_d;
      fcount_q <= fcount_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign pixel_r     = pix_q[PW-1 -: CB];
  assign pixel_g     = pix_q[2*CB-1 -: CB];
  assign pixel_b     = pix_q[CB-1:0];
  assign hcount      = hcount_q;
  assign vcount      = vcount_q;
  assign frame_start = fstart_q;
  assign frame_count = fcount_q;

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Parametrised successor to the fixed-VGA sync/colorbar generator.
- Produces programmable video timing (any H/V geometry and sync polarity), a run-time selectable test pattern, pixel coordinates and a frame counter.
- Drives logo_overlay / dvi_encoder_gw on the pixel clock domain.
- Pattern changes take effect only at frame boundaries, so no torn frames.

Parameters:
- H_TOTAL, 800, total clocks per line
- H_SYNC, 96, hsync width in clocks
- H_BACKP, 48, horizontal back porch in clocks
- H_ACTIVE, 640, active pixels per line
- V_TOTAL, 525, total lines per frame
- V_SYNC, 2, vsync width in lines
- V_BACKP, 33, vertical back porch in lines
- V_ACTIVE, 480, active lines per frame
- HSYNC_POL, 0, hsync active level (0 = active-low)
- VSYNC_POL, 0, vsync active level (0 = active-low)
- COLOR_BITS, 8, bits per colour component

Ports:
- clock  in  1  pixel clock
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  count enable; low freezes the generator
- pattern_sel  in  2  0 colorbar, 1 gray ramp, 2 grid, 3 solid
- solid_color  in  3*COLOR_BITS  {R,G,B} used by pattern 3
- hsync  out  1  horizontal sync, polarity per HSYNC_POL
- vsync  out  1  vertical sync, polarity per VSYNC_POL
- de  out  1  active-video enable
- pixel_r / pixel_g / pixel_b  out  COLOR_BITS each  pattern pixel
- hcount  out  12  active x coordinate, valid while de=1
- vcount  out  12  active y coordinate, valid while de=1
- frame_start  out  1  one-cycle pulse marking the first clock of a frame
- frame_count  out  8  completed-frame counter

Behaviour:
- Clock and reset: single clock. reset_n is asynchronous assert, synchronous release.
- Reset values:
  - hsync = ~HSYNC_POL, vsync = ~VSYNC_POL
  - de = 0, all pixel outputs = 0, hcount = vcount = 0
  - frame_start = 0, frame_count = 0
  - internal hcnt = vcnt = 0, shadow pattern = 0
- Counters: hcnt runs 0..H_TOTAL-1 and wraps to 0. vcnt increments when hcnt wraps and runs 0..V_TOTAL-1, then wraps to 0.
- Sync decode:
  - hsync is active for hcnt < H_SYNC.
  - vsync is active for vcnt < V_SYNC.
  - de is active for H_SYNC+H_BACKP <= hcnt < H_SYNC+H_BACKP+H_ACTIVE, and the same window on vcnt with the V parameters.
- Coordinates: x = hcnt - (H_SYNC+H_BACKP) and y = vcnt - (V_SYNC+V_BACKP), each zero-extended to 12 bits.
- Latency: every output is registered exactly 1 clock after the counter state it decodes. All outputs are mutually aligned.
- Pattern shadow: pattern_sel and solid_color are captured into shadow registers only when the counter is at (0,0) with enable=1. Mid-frame changes have no effect until the next frame.
- Patterns (while de=1):
  - 0, colorbar: 8 bars of width H_ACTIVE/8, in order white, yellow, cyan, green, magenta, red, blue, black. Full scale is all ones. The remainder pixels beyond 8 bars are black.
  - 1, gray ramp: R = G = B = x[COLOR_BITS-1:0].
  - 2, grid: white when x[4:0]==0 or y[4:0]==0, otherwise black.
  - 3, solid: shadow solid_color.
- Blanking: while de=0, pixel outputs are 0 and hcount/vcount hold 0.
- frame_start: high for exactly the one output cycle that corresponds to counter (0,0).
- frame_count: increments on the wrap from (H_TOTAL-1, V_TOTAL-1) to (0,0) and wraps 255 -> 0.
- enable=0: counters, shadows and all outputs hold their current values. frame_start is forced to 0 while enable=0. Counting resumes from the held position.
- Reset mid-frame: all state returns to the reset values, with no partial frame_start.

Optional Feature:
- Macro: VIDEO_TIMING_GEN_SCROLL_EN.
- Defined: patterns 0 and 1 use xs = x + frame_count, reduced by H_ACTIVE when xs >= H_ACTIVE (one conditional subtract). The image scrolls 1 pixel per frame.
- Undefined: xs = x, so the patterns are static and no adder or subtractor logic is present.

Test Plan:
- Reset release, default parameters:
  - hsync low for 96 clocks in every 800-clock line
  - vsync low for exactly 1600 clocks per 420000-clock frame
  - frame_start period = 420000 clocks
- Pattern 0:
  - first active pixel of line y=0 = FFFFFF
  - x=80 -> FFFF00
  - x=639 -> 000000
  - de high for exactly 640 clocks per active line, 480 active lines
- Pattern_sel changed from 0 to 3 mid-frame with solid_color=123456:
  - rest of the current frame is still colorbar
  - next frame is all 123456
- enable low for 50 clocks mid-line:
  - all outputs frozen for those clocks
  - after resume the line still totals 800 enabled clocks
  - frame_count is unaffected
- Run 256 frames: frame_count wraps 255 -> 0, coincident with the frame_start pulse.
- With VIDEO_TIMING_GEN_SCROLL_EN defined and pattern 1:
  - frame 1, x=0 -> 010101
  - frame 2, x=639 -> 010101 (xs = 641 - 640)
- Asynchronous reset asserted mid-frame: outputs reach their reset values without waiting for a clock edge.
